uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, DBIT data bits, SB_TICK stop ticks.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and a parity_err output.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       ckht,
    input  logic       rst_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    // Tick counter must reach SB_TICK-1 in STOP, so it widens for two stop bits.
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    localparam logic [SW-1:0] S_HALF = SW'(7);
    localparam logic [SW-1:0] S_FULL = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    logic          r_sync1, r_sync2;
    logic [2:0]    r_state, w_state_nxt;
    logic [SW-1:0] r_s, w_s_nxt;
    logic [2:0]    r_n, w_n_nxt;
    logic [7:0]    r_b, w_b_nxt;
    logic [7:0]    r_dout, w_dout_nxt;
    logic          r_done, w_done_nxt;
    logic          r_ferr, w_ferr_nxt;
    logic          w_rxs;
    logic [7:0]    w_data;
`ifdef UART_RX_PARITY_EN
    logic          r_par, w_par_nxt;
    logic          r_perr, w_perr_nxt;
`endif

    assign w_rxs  = r_sync2;
    // Bits enter at the MSB, so a short frame ends up left-aligned in r_b.
    assign w_data = r_b >> (8 - DBIT);

    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_HALF) begin
                        w_s_nxt = '0;
                        if (!w_rxs) begin
                            w_state_nxt = ST_DATA;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_FULL) begin
                        w_s_nxt = '0;
                        w_b_nxt = {w_rxs, r_b[7:1]};
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_n_nxt = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_FULL) begin
                        w_s_nxt     = '0;
                        w_par_nxt   = w_rxs;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP) begin
                        w_s_nxt     = '0;
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_dout_nxt  = w_data;
                        w_ferr_nxt  = ~w_rxs;
`ifdef UART_RX_PARITY_EN
                        w_perr_nxt  = (^w_data) ^ r_par;
`endif
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised at 16 ticks per bit, and the expected
// {parity_err, frame_err, dout} of every valid frame is queued and popped on rx_done_tick.
module tb_uart_rx;

    logic       ckht = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       obs_perr;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    assign obs_perr = parity_err;
`else
    assign obs_perr = 1'b0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         done_count = 0;
    int         tick_cnt = 0;
    logic       prev_done = 1'b0;
    logic [9:0] exp_q[$];

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .ckht         (ckht),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );

    always #5 ckht = ~ckht;

    // One-cycle s_tick every 27 clocks, changed on the falling edge.
    initial forever begin
        @(negedge ckht);
        s_tick = (tick_cnt == 26);
        tick_cnt = (tick_cnt == 26) ? 0 : tick_cnt + 1;
    end

    // Output monitor: pops the scoreboard on every rx_done_tick.
    initial forever begin
        logic [9:0] exp_v;
        @(negedge ckht);
        if (rx_done_tick === 1'b1) begin
            done_count++;
            checks++;
            assert (prev_done === 1'b0) else begin
                errors++;
                $error("FAIL done_width observed=%b expected=%b", prev_done, 1'b0);
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed dout=%h expected no pulse", dout);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                assert ({obs_perr, frame_err, dout} === exp_v) else begin
                    errors++;
                    $error("FAIL frame observed perr/ferr/dout=%b/%b/%h expected=%b/%b/%h",
                           obs_perr, frame_err, dout, exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
        prev_done = rx_done_tick;
    end

    task automatic wait_tick();
        @(posedge ckht);
        while (s_tick !== 1'b1) @(posedge ckht);
        #1;
    endtask

    task automatic send_bit(input logic val, input int ticks);
        rx = val;
        repeat (ticks) wait_tick();
    endtask

    // Low stop bits return high after 12 ticks so the tail is not taken as a new start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        logic exp_perr;
`ifdef UART_RX_PARITY_EN
        exp_perr = (^data) ^ par;
`else
        exp_perr = 1'b0;
`endif
        exp_q.push_back({exp_perr, ~stop, data});
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit(par, 16);
`endif
        if (stop) begin
            send_bit(1'b1, 16);
        end else begin
            send_bit(1'b0, 12);
            send_bit(1'b1, 4);
        end
    endtask

    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        int done_before;
        logic [7:0] par_in;

        // Reset state, while asserted and just after release.
        repeat (3) @(posedge ckht);
        #1;
        check_val("reset_outputs", {obs_perr, frame_err, dout}, 10'h000);
        check_val("reset_done", {9'd0, rx_done_tick}, 10'd0);
        rst_n = 1'b1;
        repeat (5) wait_tick();
        check_val("post_reset_outputs", {obs_perr, frame_err, dout}, 10'h000);

        // 0x55 with a valid stop bit.
        par_in = 8'h55;
        send_frame(par_in, 1'b1, ^par_in);
        send_bit(1'b1, 10);
        check_val("count_55", 10'(done_count), 10'd1);

        // Start glitch: 3 ticks low then high.
        done_before = done_count;
        send_bit(1'b0, 3);
        send_bit(1'b1, 30);
        check_val("glitch_no_done", 10'(done_count), 10'(done_before));
        check_val("glitch_dout_kept", {2'b00, dout}, 10'h055);

        // 0xA3 with a low stop bit.
        par_in = 8'hA3;
        send_frame(par_in, 1'b0, ^par_in);
        send_bit(1'b1, 20);
        check_val("ferr_held", {9'd0, frame_err}, 10'd1);

        // Back-to-back 0x00, 0xFF.
        send_frame(8'h00, 1'b1, 1'b0);
        check_val("b2b_first_dout", {2'b00, dout}, 10'h000);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1, 10);
        check_val("count_b2b", 10'(done_count), 10'd4);

        // Reset pulsed during bit 4 of 0x3C; that frame must not complete.
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(par_in[i] ^ par_in[i] ^ (i >= 2), 16);
        send_bit(1'b1, 6);
        rst_n = 1'b0;
        repeat (3) @(posedge ckht);
        #1;
        check_val("midframe_reset_outputs", {obs_perr, frame_err, dout}, 10'h000);
        rst_n = 1'b1;
        send_bit(1'b1, 40);
        check_val("midframe_no_done", 10'(done_count), 10'd4);
        send_frame(8'h81, 1'b1, 1'b0);
        send_bit(1'b1, 10);
        check_val("after_reset_dout", {2'b00, dout}, 10'h081);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1, 10);
        check_val("parity_bad", {9'd0, obs_perr}, 10'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1, 10);
        check_val("parity_good", {9'd0, obs_perr}, 10'd0);
`endif

        send_bit(1'b1, 20);
        check_val("scoreboard_drained", 10'(exp_q.size()), 10'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
